// File: rtl/sys2by2_pkg.sv
// Shared types and constants for the 2x2 systolic convolution datapath.
package sys2by2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    localparam logic [1:0] ADDR_C11 = 2'b00;
    localparam logic [1:0] ADDR_C12 = 2'b10;
    localparam logic [1:0] ADDR_C21 = 2'b01;
    localparam logic [1:0] ADDR_C22 = 2'b11;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_PASSES = 2;

    // Entry index matches the read address encoding: bit1 = column, bit0 = row.
    function automatic logic [1:0] entry_idx(input logic col, input logic row);
        return {col, row};
    endfunction

endpackage

// File: rtl/psum_buffer_2by2_sat_acc.sv
// Signed saturating accumulator: sign-extends a partial sum and adds it to an entry.
module sat_acc #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 20
) (
    input  logic [DATA_W-1:0] din,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] wide_s;

    // One guard bit catches overflow in either direction; clamp to the signed range.
    always_comb begin
        wide_s = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DATA_W){din[DATA_W-1]}}, din};
        ovf    = wide_s[ACC_W] ^ wide_s[ACC_W-1];
        if (ovf) begin
            sum = wide_s[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            sum = wide_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/psum_buffer_2by2.sv
// Result buffer for the 2x2 systolic array: accumulates per-column psum streams
// into C11/C12/C21/C22 over PASSES passes and serves registered reads.
module psum_buffer_2by2
    import sys2by2_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int PASSES = DEF_PASSES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sys_2by2_en,
    input  logic [1:0]        psum_valid,
    input  logic [DATA_W-1:0] psum_in_0,
    input  logic [DATA_W-1:0] psum_in_1,
    input  logic [1:0]        buffer_read_addr_in,
    output logic [ACC_W-1:0]  buffer_data_out,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int              CNT_W   = $clog2(2 * PASSES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * PASSES);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ACC_W-1:0]  entry_r [4];
    logic [CNT_W-1:0]  cnt_r [2];
    logic [CNT_W-1:0]  cnt_nxt_s [2];
    logic [DATA_W-1:0] psum_s [2];
    logic [ACC_W-1:0]  sum_s [2];
    logic [1:0]        sat_s;
    logic [1:0]        accept_s;
    logic [1:0]        drop_s;

    assign psum_s[0] = psum_in_0;
    assign psum_s[1] = psum_in_1;

    for (genvar j = 0; j < 2; j++) begin : g_col
        sat_acc #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_sat_acc (
            .din (psum_s[j]),
            .acc (entry_r[entry_idx(1'(j), cnt_r[j][0])]),
            .sum (sum_s[j]),
            .ovf (sat_s[j])
        );
    end

    // Beat qualification; beats in a start cycle are discarded outright.
    always_comb begin
        accept_s     = 2'b00;
        drop_s       = 2'b00;
        cnt_nxt_s[0] = cnt_r[0];
        cnt_nxt_s[1] = cnt_r[1];
        for (int j = 0; j < 2; j++) begin
            if (sys_2by2_en && psum_valid[j] && !start) begin
                if (state_r == ST_COLLECT && cnt_r[j] != CNT_MAX) begin
                    accept_s[j]  = 1'b1;
                    cnt_nxt_s[j] = cnt_r[j] + CNT_W'(1);
                end else if (state_r == ST_COLLECT || state_r == ST_FULL) begin
                    drop_s[j] = 1'b1;
                end else begin
                    drop_s[j] = 1'b0;
                end
            end else begin
                accept_s[j] = 1'b0;
            end
        end
    end

    // Next-state decode; FULL is reached using post-edge counter values.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_COLLECT;
                else       state_nxt_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (start) state_nxt_s = ST_COLLECT;
                else if (cnt_nxt_s[0] == CNT_MAX && cnt_nxt_s[1] == CNT_MAX) state_nxt_s = ST_FULL;
                else       state_nxt_s = ST_COLLECT;
            end
            ST_FULL: begin
                if (start) state_nxt_s = ST_COLLECT;
                else       state_nxt_s = ST_FULL;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, entries, counters, sticky overflow and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            entry_r         <= '{default: '0};
            cnt_r           <= '{default: '0};
            buffer_data_out <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            buffer_data_out <= entry_r[buffer_read_addr_in];
            busy            <= (state_nxt_s == ST_COLLECT);
            done            <= (state_nxt_s == ST_FULL);
            if (start) begin
                entry_r  <= '{default: '0};
                cnt_r    <= '{default: '0};
                overflow <= 1'b0;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    cnt_r[j] <= cnt_nxt_s[j];
                    if (accept_s[j]) begin
                        entry_r[entry_idx(1'(j), cnt_r[j][0])] <= sum_s[j];
                    end
                end
                overflow <= overflow | (|(accept_s & sat_s)) | (|drop_s);
            end
        end
    end

endmodule

// File: tb/tb_psum_buffer_2by2.sv
// Scenario-driven bench for psum_buffer_2by2 with a read-data scoreboard queue.
module tb_psum_buffer_2by2;
    import sys2by2_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sys_2by2_en;
    logic [1:0]  psum_valid;
    logic [15:0] psum_in_0;
    logic [15:0] psum_in_1;
    logic [1:0]  buffer_read_addr_in;
    logic [19:0] data_out;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] data_out16;
    logic        busy16;
    logic        done16;
    logic        overflow16;

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_v;

    psum_buffer_2by2 dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .sys_2by2_en         (sys_2by2_en),
        .psum_valid          (psum_valid),
        .psum_in_0           (psum_in_0),
        .psum_in_1           (psum_in_1),
        .buffer_read_addr_in (buffer_read_addr_in),
        .buffer_data_out     (data_out),
        .busy                (busy),
        .done                (done),
        .overflow            (overflow)
    );

    psum_buffer_2by2 #(.DATA_W(16), .ACC_W(16), .PASSES(2)) dut16 (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .sys_2by2_en         (sys_2by2_en),
        .psum_valid          (psum_valid),
        .psum_in_0           (psum_in_0),
        .psum_in_1           (psum_in_1),
        .buffer_read_addr_in (buffer_read_addr_in),
        .buffer_data_out     (data_out16),
        .busy                (busy16),
        .done                (done16),
        .overflow            (overflow16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] v, input int p0, input int p1, input logic en);
        psum_valid  = v;
        psum_in_0   = 16'(p0);
        psum_in_1   = 16'(p1);
        sys_2by2_en = en;
        tick();
        psum_valid  = 2'b00;
        sys_2by2_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] addrs [4] = '{ADDR_C11, ADDR_C12, ADDR_C21, ADDR_C22};
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            buffer_read_addr_in = addrs[i];
            exp_q.push_back(20'd0);
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp_v) begin n_fail++; $display("FAIL reset_read[%0d] got %0d want %0d", i, data_out, exp_v); end
        end
    endtask

    task automatic test_collect();
        int c0 [4] = '{1, 2, 3, 4};
        int c1 [4] = '{10, 20, 30, 40};
        logic [19:0] rd_exp [4] = '{20'd0, 20'd1, 20'd1, 20'd4};
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL collect_busy got %0b want 1", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL collect_done0 got %0b want 0", done); end
        buffer_read_addr_in = ADDR_C11;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rd_exp[i]);
            beat(2'b11, c0[i], c1[i], 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp_v) begin n_fail++; $display("FAIL collect_prewrite_read[%0d] got %0d want %0d", i, data_out, exp_v); end
            n_checks++;
            if (done !== (i == 3)) begin n_fail++; $display("FAIL collect_done[%0d] got %0b want %0b", i, done, (i == 3)); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL collect_busy_fall got %0b want 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL collect_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_reads();
        logic [1:0]  addrs [4] = '{ADDR_C11, ADDR_C12, ADDR_C21, ADDR_C22};
        logic [19:0] vals [4]  = '{20'd4, 20'd40, 20'd6, 20'd60};
        for (int i = 0; i < 4; i++) begin
            buffer_read_addr_in = addrs[i];
            exp_q.push_back(vals[i]);
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp_v) begin n_fail++; $display("FAIL read_seq[%0d] got %0d want %0d", i, data_out, exp_v); end
        end
    endtask

    task automatic test_enable_gating();
        logic [1:0]  addrs [4] = '{ADDR_C11, ADDR_C12, ADDR_C21, ADDR_C22};
        logic [19:0] vals [4]  = '{20'd4, 20'd40, 20'd6, 20'd60};
        // beats in the start cycle must be discarded
        psum_valid = 2'b11; psum_in_0 = 16'd500; psum_in_1 = 16'd500; sys_2by2_en = 1'b1;
        pulse_start();
        psum_valid = 2'b00; sys_2by2_en = 1'b0;
        beat(2'b11, 999, 999, 1'b0);
        beat(2'b01, 1, 0, 1'b1);
        beat(2'b11, 777, 777, 1'b0);
        beat(2'b10, 0, 10, 1'b1);
        beat(2'b01, 2, 0, 1'b1);
        beat(2'b10, 0, 20, 1'b1);
        beat(2'b00, 55, 55, 1'b1);
        beat(2'b01, 3, 0, 1'b1);
        beat(2'b11, 0, 0, 1'b0);
        beat(2'b10, 0, 30, 1'b1);
        beat(2'b01, 4, 0, 1'b1);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL gate_done_early got %0b want 0", done); end
        beat(2'b10, 0, 40, 1'b1);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gate_done got %0b want 1", done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL gate_overflow got %0b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            buffer_read_addr_in = addrs[i];
            exp_q.push_back(vals[i]);
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp_v) begin n_fail++; $display("FAIL gate_read[%0d] got %0d want %0d", i, data_out, exp_v); end
        end
    endtask

    task automatic test_drop_and_restart();
        logic [1:0]  addrs [4] = '{ADDR_C11, ADDR_C12, ADDR_C21, ADDR_C22};
        logic [19:0] vals [4]  = '{20'd4, 20'd40, 20'd6, 20'd60};
        beat(2'b01, 100, 0, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow got %0b want 1", overflow); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL drop_done got %0b want 1", done); end
        for (int i = 0; i < 4; i++) begin
            buffer_read_addr_in = addrs[i];
            exp_q.push_back(vals[i]);
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp_v) begin n_fail++; $display("FAIL drop_read[%0d] got %0d want %0d", i, data_out, exp_v); end
        end
        pulse_start();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL restart_overflow got %0b want 0", overflow); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %0b want 1", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done got %0b want 0", done); end
        for (int i = 0; i < 4; i++) begin
            buffer_read_addr_in = addrs[i];
            exp_q.push_back(20'd0);
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp_v) begin n_fail++; $display("FAIL restart_read[%0d] got %0d want %0d", i, data_out, exp_v); end
        end
    endtask

    task automatic test_saturation();
        // beats 1 and 3 of column 0 both land on C11
        beat(2'b01, 32767, 0, 1'b1);
        beat(2'b01, 0, 0, 1'b1);
        beat(2'b01, 32767, 0, 1'b1);
        n_checks++; if (overflow16 !== 1'b1) begin n_fail++; $display("FAIL sat16_overflow got %0b want 1", overflow16); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat20_overflow got %0b want 0", overflow); end
        buffer_read_addr_in = ADDR_C11;
        exp_q.push_back(20'h07FFF);
        exp_q.push_back(20'd65534);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++; if ({4'h0, data_out16} !== exp_v) begin n_fail++; $display("FAIL sat16_value got %0d want %0d", data_out16, exp_v); end
        exp_v = exp_q.pop_front();
        n_checks++; if (data_out !== exp_v) begin n_fail++; $display("FAIL sat20_value got %0d want %0d", data_out, exp_v); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] addrs [4] = '{ADDR_C11, ADDR_C12, ADDR_C21, ADDR_C22};
        pulse_start();
        beat(2'b11, 5, 6, 1'b1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %0b want 1", busy); end
        rst = 1'b1; start = 1'b1; psum_valid = 2'b11; sys_2by2_en = 1'b1;
        psum_in_0 = 16'd9; psum_in_1 = 16'd9;
        tick();
        rst = 1'b0; start = 1'b0; psum_valid = 2'b00; sys_2by2_en = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %0b want 0", done); end
        for (int i = 0; i < 4; i++) begin
            buffer_read_addr_in = addrs[i];
            exp_q.push_back(20'd0);
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (data_out !== exp_v) begin n_fail++; $display("FAIL mid_rst_read[%0d] got %0d want %0d", i, data_out, exp_v); end
        end
        // IDLE beats are silently ignored
        beat(2'b11, 7, 7, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_overflow got %0b want 0", overflow); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b want 0", busy); end
        buffer_read_addr_in = ADDR_C11;
        exp_q.push_back(20'd0);
        tick();
        exp_v = exp_q.pop_front();
        n_checks++; if (data_out !== exp_v) begin n_fail++; $display("FAIL idle_read got %0d want %0d", data_out, exp_v); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sys_2by2_en = 1'b0; psum_valid = 2'b00;
        psum_in_0 = 16'd0; psum_in_1 = 16'd0; buffer_read_addr_in = 2'b00;
        test_reset();
        test_collect();
        test_reads();
        test_enable_gating();
        test_drop_and_restart();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
